mpscm_wr_arbiter: RTL

Write-port arbiter and scheduler for the multi-port register file (`mpscm`). It accepts write-back requests from `NREQ` independent producers through valid/ready handshakes and grants up to `WP` of them per cycle using a round-robin priority pointer. It guarantees that no two register-file write ports target the same row in one cycle, and it absorbs writes to row 0. Granted writes are registered and drive the register file's `WE`/`WADDR`/`DIN` directly.

---
 rtl/mpscm_wr_arbiter_if.sv | 42 ++++
 rtl/mpscm_wr_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mpscm_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mpscm_wr_arbiter_if
// Purpose  : Bundles the write-back request handshake and the register-file
//            write-port bus of the mpscm write arbiter.
// Ports    : (signals)
//   REQ_VALID / REQ_READY   per-requester valid/ready handshake
//   REQ_ADDR  / REQ_DATA    per-requester target row and write data
//   WE / WADDR / DIN        registered register-file write ports
//   PEND                    rows with an outstanding write
//   CONFLICT_CNT            saturating count of stalled cycles
// Modports : master = requesters + register file, slave = arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface mpscm_wr_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int WP         = 3,
  parameter int ROWS       = 32,
  parameter int ADDR_WIDTH = $clog2(ROWS),
  parameter int DATA_WIDTH = 32
);
  logic [NREQ-1:0]       REQ_VALID;
  logic [NREQ-1:0]       REQ_READY;
  logic [ADDR_WIDTH-1:0] REQ_ADDR [NREQ];
  logic [DATA_WIDTH-1:0] REQ_DATA [NREQ];
  logic [WP-1:0]         WE;
  logic [ADDR_WIDTH-1:0] WADDR [WP];
  logic [DATA_WIDTH-1:0] DIN [WP];
  logic [ROWS-1:0]       PEND;
  logic [15:0]           CONFLICT_CNT;

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA,
    input  REQ_READY, WE, WADDR, DIN, PEND, CONFLICT_CNT
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA,
    output REQ_READY, WE, WADDR, DIN, PEND, CONFLICT_CNT
  );
endinterface
`default_nettype wire

// File: rtl/mpscm_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mpscm_wr_arbiter
// Purpose  : Round-robin write-port arbiter for the multi-port register file.
//            Grants up to WP nonzero-row writes per cycle, never two to the
//            same row, absorbs row-0 writes, and registers the winners onto
//            the register-file WE/WADDR/DIN ports.
// Ports    :
//   CLK   in   clock, all state on the rising edge
//   RST   in   synchronous active-high reset
//   bus   slave modport of mpscm_wr_arbiter_if (handshake + write ports)
// Revision : 1.0 - initial release
// ============================================================================
module mpscm_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int WP         = 3,
  parameter int ROWS       = 32,
  parameter int ADDR_WIDTH = $clog2(ROWS),
  parameter int DATA_WIDTH = 32
) (
  input wire logic          CLK,
  input wire logic          RST,
  mpscm_wr_arbiter_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NP_W  = $clog2(WP + 1);

  // Registered state
  logic [PTR_W-1:0]      ptr_q;
  logic [WP-1:0]         we_q;
  logic [ADDR_WIDTH-1:0] waddr_q [WP];
  logic [DATA_WIDTH-1:0] din_q [WP];
  logic [15:0]           cnt_q;

  // Next-state / combinational
  logic [PTR_W-1:0]      ptr_d;
  logic [WP-1:0]         we_d;
  logic [ADDR_WIDTH-1:0] waddr_d [WP];
  logic [DATA_WIDTH-1:0] din_d [WP];
  logic [NREQ-1:0]       rdy;
  logic                  stall;
  logic [ROWS-1:0]       pend;

  // Scan temporaries
  logic [PTR_W:0]        pos;
  logic [PTR_W-1:0]      idx;
  logic [NP_W-1:0]       nport;
  logic                  dup;
  logic                  hit;

  // Grant scan: walk requesters from ptr_q in round-robin order. Each nonzero
  // grant takes the next free port; the port slots filled so far double as
  // the list of rows already claimed this cycle.
  always_comb begin
    rdy   = '0;
    we_d  = '0;
    for (int k = 0; k < WP; k++) begin
      waddr_d[k] = '0;
      din_d[k]   = '0;
    end
    ptr_d = ptr_q;
    stall = 1'b0;
    nport = '0;
    pos   = '0;
    idx   = '0;
    dup   = 1'b0;
    hit   = 1'b0;

    for (int j = 0; j < NREQ; j++) begin
      // (ptr + j) mod NREQ without a divider; sum never exceeds 2*NREQ-2
      pos = {1'b0, ptr_q} + (PTR_W+1)'(j);
      if (pos >= (PTR_W+1)'(NREQ)) begin
        pos = pos - (PTR_W+1)'(NREQ);
      end
      idx = pos[PTR_W-1:0];
      hit = 1'b0;

      if (bus.REQ_VALID[idx]) begin
        if (bus.REQ_ADDR[idx] == '0) begin
          // Row 0 is hardwired: accept and drop, no port consumed
          hit = 1'b1;
        end else begin
          dup = 1'b0;
          for (int k = 0; k < WP; k++) begin
            if ((NP_W'(k) < nport) && (waddr_d[k] == bus.REQ_ADDR[idx])) begin
              dup = 1'b1;
            end
          end
          if (!dup && (nport < NP_W'(WP))) begin
            hit = 1'b1;
            for (int k = 0; k < WP; k++) begin
              if (nport == NP_W'(k)) begin
                we_d[k]    = 1'b1;
                waddr_d[k] = bus.REQ_ADDR[idx];
                din_d[k]   = bus.REQ_DATA[idx];
              end
            end
            nport = nport + 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
      end

      if (hit) begin
        rdy[idx] = 1'b1;
        ptr_d    = (idx == PTR_W'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Rows with a write either still being requested or sitting in the port stage
  always_comb begin
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.REQ_VALID[i]) begin
        pend[bus.REQ_ADDR[i]] = 1'b1;
      end
    end
    for (int k = 0; k < WP; k++) begin
      if (we_q[k]) begin
        pend[waddr_q[k]] = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
      we_q  <= '0;
      for (int k = 0; k < WP; k++) begin
        waddr_q[k] <= '0;
        din_q[k]   <= '0;
      end
      cnt_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      if (stall && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Reset blocks acceptance in the same cycle it is asserted
  assign bus.REQ_READY    = RST ? '0 : rdy;
  assign bus.WE           = we_q;
  assign bus.PEND         = pend;
  assign bus.CONFLICT_CNT = cnt_q;

  for (genvar k = 0; k < WP; k++) begin : g_port
    assign bus.WADDR[k] = waddr_q[k];
    assign bus.DIN[k]   = din_q[k];
  end

endmodule
`default_nettype wire
